// File: rtl/cmp_pkg.sv
// Shared definitions for the comparator result debouncer.
// Provides the relation codes published on out_state, the debouncer FSM
// state encoding, and a decoder that turns the comparator's one-hot
// Sm/Eq/Gt flags into a relation code plus a legality bit.
package cmp_pkg;

   localparam logic [1:0] CMP_NONE = 2'b00;
   localparam logic [1:0] CMP_SM   = 2'b01;
   localparam logic [1:0] CMP_EQ   = 2'b10;
   localparam logic [1:0] CMP_GT   = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_TRACK  = 2'b01,
      ST_LOCKED = 2'b10
   } cmp_state_t;

   // Returns {legal, code}. Only a strictly one-hot flag set is legal.
   function automatic logic [2:0] cmp_decode(input logic eq, input logic gt, input logic sm);
      logic [2:0] result;
      case ({sm, eq, gt})
         3'b100:  result = {1'b1, CMP_SM};
         3'b010:  result = {1'b1, CMP_EQ};
         3'b001:  result = {1'b1, CMP_GT};
         default: result = {1'b0, CMP_NONE};
      endcase
      return result;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   clr   - synchronous clear, wins over inc
//   inc   - count up by one this cycle (ignored once all-ones)
//   value - current count
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] value
);

   // The count sticks at all-ones rather than wrapping back to zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value <= '0;
      end else if (clr) begin
         value <= '0;
      end else if (inc && (value != '1)) begin
         value <= value + 1'b1;
      end
   end

endmodule

// File: rtl/cmp_result_debouncer.sv
// Debounces the Eq/Gt/Sm flags of the 4-bit magnitude comparator.
// A relation is published only after STABLE_CNT consecutive identical
// valid samples; idle cycles (in_valid=0) do not break a run. Once a
// relation is published it is held until a different relation has been
// stable for a full run (hysteresis). Illegal flag patterns set a sticky
// error and restart tracking without disturbing the published relation.
// Ports:
//   clk          - rising-edge clock
//   rst_n        - asynchronous active-low reset
//   clr          - synchronous clear, same effect as reset, beats in_valid
//   in_valid     - eq/gt/sm carry a sample this cycle
//   eq, gt, sm   - comparator A==B, A>B, A<B flags
//   out_valid    - a stable relation has been published
//   out_state    - published relation: 00 none, 01 SM, 10 EQ, 11 GT
//   change_pulse - one-cycle pulse when the published relation changes
//   gt_count     - saturating count of entries into published GT
//   err          - sticky illegal-flag indicator
module cmp_result_debouncer
   import cmp_pkg::*;
#(
   parameter int STABLE_CNT = 4,
   parameter int CNT_W      = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             in_valid,
   input  logic             eq,
   input  logic             gt,
   input  logic             sm,
   output logic             out_valid,
   output logic [1:0]       out_state,
   output logic             change_pulse,
   output logic [CNT_W-1:0] gt_count,
   output logic             err
);

   localparam logic [7:0] STABLE_RUN = 8'(STABLE_CNT);

   cmp_state_t state, state_next;
   logic [1:0] candidate, cand_next;
   logic [7:0] run, run_next;
   logic [2:0] dec;
   logic       legal;
   logic [1:0] code;
   logic       publish;
   logic       illegal;
   logic       changed;
   logic       out_valid_next;
   logic [1:0] out_state_next;
   logic       change_next;
   logic       err_next;
   logic       gt_inc;

   assign dec   = cmp_decode(eq, gt, sm);
   assign legal = dec[2];
   assign code  = dec[1:0];

   // State register plus all registered outputs. clr behaves exactly like
   // reset but synchronously, and it discards any sample presented with it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         candidate    <= CMP_NONE;
         run          <= '0;
         out_valid    <= 1'b0;
         out_state    <= CMP_NONE;
         change_pulse <= 1'b0;
         err          <= 1'b0;
      end else if (clr) begin
         state        <= ST_IDLE;
         candidate    <= CMP_NONE;
         run          <= '0;
         out_valid    <= 1'b0;
         out_state    <= CMP_NONE;
         change_pulse <= 1'b0;
         err          <= 1'b0;
      end else begin
         state        <= state_next;
         candidate    <= cand_next;
         run          <= run_next;
         out_valid    <= out_valid_next;
         out_state    <= out_state_next;
         change_pulse <= change_next;
         err          <= err_next;
      end
   end

   // Next-state logic. A sample that differs from the tracked candidate
   // starts a fresh run of length one; a run reaching STABLE_RUN publishes
   // on the same edge that accepts the qualifying sample. In LOCKED the
   // run counter is left at STABLE_RUN while matching samples arrive.
   always_comb begin
      state_next = state;
      cand_next  = candidate;
      run_next   = run;
      publish    = 1'b0;
      illegal    = 1'b0;
      if (in_valid) begin
         if (!legal) begin
            illegal    = 1'b1;
            state_next = ST_IDLE;
            cand_next  = CMP_NONE;
            run_next   = '0;
         end else begin
            case (state)
               ST_IDLE: begin
                  cand_next  = code;
                  run_next   = 8'd1;
                  state_next = ST_TRACK;
                  publish    = (STABLE_RUN == 8'd1);
               end
               ST_TRACK: begin
                  if (code == candidate) begin
                     run_next = run + 8'd1;
                     publish  = ((run + 8'd1) == STABLE_RUN);
                  end else begin
                     cand_next = code;
                     run_next  = 8'd1;
                     publish   = (STABLE_RUN == 8'd1);
                  end
               end
               ST_LOCKED: begin
                  if (code != out_state) begin
                     cand_next  = code;
                     run_next   = 8'd1;
                     state_next = ST_TRACK;
                     publish    = (STABLE_RUN == 8'd1);
                  end
               end
               default: begin
                  state_next = ST_IDLE;
                  cand_next  = CMP_NONE;
                  run_next   = '0;
               end
            endcase
            if (publish) begin
               state_next = ST_LOCKED;
            end
         end
      end
   end

   // Output logic. A publish that re-confirms the current relation (possible
   // after a flicker that never completed a run) neither pulses nor counts.
   always_comb begin
      changed        = !out_valid || (cand_next != out_state);
      out_valid_next = out_valid;
      out_state_next = out_state;
      change_next    = 1'b0;
      err_next       = err | illegal;
      gt_inc         = 1'b0;
      if (publish) begin
         out_valid_next = 1'b1;
         out_state_next = cand_next;
         change_next    = changed;
         gt_inc         = changed && (cand_next == CMP_GT);
      end
   end

   sat_counter #(
      .W(CNT_W)
   ) u_gt_counter (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (clr),
      .inc  (gt_inc),
      .value(gt_count)
   );

endmodule
